// File: rtl/nn_pkg.sv
// Shared types and default widths for the training sequencer datapath.
// Imported by the sequencer top and its accumulator sub-module.
package nn_pkg;

    localparam int DEF_BITS     = 16;
    localparam int DEF_ACC_BITS = 32;
    localparam int DEF_PAT_BITS = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TR_FWD,
        S_TR_BWD,
        S_VL_FWD,
        S_EVAL,
        S_FINISH
    } seq_state_t;

endpackage

// File: rtl/sat_accum.sv
// Saturating unsigned accumulator with synchronous clear and add enable.
// With a constant add of 1 it serves as a saturating counter.
module sat_accum
    import nn_pkg::*;
#(
    parameter int W  = DEF_ACC_BITS,
    parameter int IW = DEF_BITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_add_en,
    input  logic [IW-1:0] i_add,
    output logic [W-1:0]  o_q
);

    logic [W-1:0] r_q;
    logic [W:0]   w_raw;
    logic [W-1:0] w_sum;

    // One extra bit catches the carry out so the sum can clamp instead of wrap
    assign w_raw = {1'b0, r_q} + {{(W + 1 - IW){1'b0}}, i_add};
    assign w_sum = w_raw[W] ? '1 : w_raw[W-1:0];
    assign o_q   = r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_add_en) begin
            r_q <= w_sum;
        end
    end

endmodule

// File: rtl/train_sequencer.sv
// Epoch/sample sequencer for training runs: train fwd/bwd, validate fwd,
// evaluate, checkpoint on improvement and stop early on a stalled run.
module train_sequencer
    import nn_pkg::*;
#(
    parameter int BITS     = DEF_BITS,
    parameter int ACC_BITS = DEF_ACC_BITS,
    parameter int PAT_BITS = DEF_PAT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BITS-1:0]     n_train,
    input  logic [BITS-1:0]     n_valid,
    input  logic [BITS-1:0]     n_epoch,
    input  logic [PAT_BITS-1:0] patience,
    input  logic [BITS-1:0]     sample_err,
    output logic                fwd_req,
    input  logic                fwd_done,
    output logic                bwd_req,
    input  logic                bwd_done,
    output logic [BITS-1:0]     sample_idx,
    output logic                tr,
    output logic                vl,
    output logic [BITS-1:0]     epoch_idx,
    output logic                save,
    output logic [ACC_BITS-1:0] best_err,
    output logic                early_stop,
    output logic                busy,
    output logic                done
);

    localparam logic [BITS-1:0]     ONE  = BITS'(1);
    localparam logic [PAT_BITS-1:0] PONE = PAT_BITS'(1);

    seq_state_t r_state;
    seq_state_t w_state_nx;

    logic [BITS-1:0]     r_n_train;
    logic [BITS-1:0]     r_n_valid;
    logic [BITS-1:0]     r_n_epoch;
    logic [PAT_BITS-1:0] r_patience;
    logic [BITS-1:0]     r_idx;
    logic [BITS-1:0]     r_epoch;
    logic [ACC_BITS-1:0] r_best;
    logic                r_save;
    logic                r_done;
    logic                r_early;

    logic [ACC_BITS-1:0] w_acc;
    logic [PAT_BITS-1:0] w_stall;
    logic [BITS-1:0]     w_epoch_nx;
    logic                w_last_tr;
    logic                w_last_vl;
    logic                w_stall_hit;

    logic w_load;
    logic w_idx_clr;
    logic w_idx_inc;
    logic w_acc_add;
    logic w_acc_clr;
    logic w_stall_inc;
    logic w_stall_clr;
    logic w_eval;
    logic w_improve;
    logic w_stop;

    assign w_last_tr  = (r_idx == r_n_train - ONE);
    assign w_last_vl  = (r_idx == r_n_valid - ONE);
    assign w_epoch_nx = r_epoch + ONE;

    // Stall never exceeds a non-zero patience, so "old stall + 1 == patience"
    // is the same test as comparing the post-increment value.
    assign w_stall_hit = (r_patience != '0) && (w_stall == r_patience - PONE);

    sat_accum #(
        .W  (ACC_BITS),
        .IW (BITS)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_acc_clr),
        .i_add_en (w_acc_add),
        .i_add    (sample_err),
        .o_q      (w_acc)
    );

    sat_accum #(
        .W  (PAT_BITS),
        .IW (1)
    ) u_stall (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_stall_clr),
        .i_add_en (w_stall_inc),
        .i_add    (1'b1),
        .o_q      (w_stall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_load      = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_acc_add   = 1'b0;
        w_acc_clr   = 1'b0;
        w_stall_inc = 1'b0;
        w_stall_clr = 1'b0;
        w_eval      = 1'b0;
        w_improve   = 1'b0;
        w_stop      = 1'b0;
        fwd_req     = 1'b0;
        bwd_req     = 1'b0;
        tr          = 1'b0;
        vl          = 1'b0;
        busy        = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_load      = 1'b1;
                    w_acc_clr   = 1'b1;
                    w_stall_clr = 1'b1;
                    if (n_epoch == '0) begin
                        w_state_nx = S_FINISH;
                    end else if (n_train != '0) begin
                        w_state_nx = S_TR_FWD;
                    end else if (n_valid != '0) begin
                        w_state_nx = S_VL_FWD;
                    end else begin
                        w_state_nx = S_EVAL;
                    end
                end
            end
            S_TR_FWD: begin
                fwd_req = 1'b1;
                tr      = 1'b1;
                if (fwd_done) begin
                    w_state_nx = S_TR_BWD;
                end
            end
            S_TR_BWD: begin
                bwd_req = 1'b1;
                tr      = 1'b1;
                if (bwd_done) begin
                    if (w_last_tr) begin
                        w_idx_clr  = 1'b1;
                        w_state_nx = (r_n_valid != '0) ? S_VL_FWD : S_EVAL;
                    end else begin
                        w_idx_inc  = 1'b1;
                        w_state_nx = S_TR_FWD;
                    end
                end
            end
            S_VL_FWD: begin
                fwd_req = 1'b1;
                vl      = 1'b1;
                if (fwd_done) begin
                    w_acc_add = 1'b1;
                    if (w_last_vl) begin
                        w_state_nx = S_EVAL;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            S_EVAL: begin
                w_eval    = 1'b1;
                w_acc_clr = 1'b1;
                w_idx_clr = 1'b1;
                w_improve = (r_n_valid != '0)
                         && ((r_epoch == '0) || (w_acc < r_best));
                w_stall_clr = w_improve;
                w_stall_inc = !w_improve;
                if (w_epoch_nx == r_n_epoch) begin
                    w_state_nx = S_FINISH;
                end else if (!w_improve && w_stall_hit) begin
                    w_stop     = 1'b1;
                    w_state_nx = S_FINISH;
                end else if (r_n_train != '0) begin
                    w_state_nx = S_TR_FWD;
                end else if (r_n_valid != '0) begin
                    w_state_nx = S_VL_FWD;
                end else begin
                    w_state_nx = S_EVAL;
                end
            end
            S_FINISH: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_train  <= '0;
            r_n_valid  <= '0;
            r_n_epoch  <= '0;
            r_patience <= '0;
            r_idx      <= '0;
            r_epoch    <= '0;
            r_best     <= '0;
            r_save     <= 1'b0;
            r_done     <= 1'b0;
            r_early    <= 1'b0;
        end else begin
            r_save <= w_eval && w_improve;
            r_done <= (r_state == S_FINISH);
            if (w_load) begin
                r_n_train  <= n_train;
                r_n_valid  <= n_valid;
                r_n_epoch  <= n_epoch;
                r_patience <= patience;
                r_epoch    <= '0;
                r_best     <= '0;
                r_early    <= 1'b0;
            end
            if (w_load || w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + ONE;
            end
            if (w_eval) begin
                r_epoch <= w_epoch_nx;
                if (w_improve) begin
                    r_best <= w_acc;
                end
                if (w_stop) begin
                    r_early <= 1'b1;
                end
            end
        end
    end

    assign sample_idx = r_idx;
    assign epoch_idx  = r_epoch;
    assign best_err   = r_best;
    assign save       = r_save;
    assign done       = r_done;
    assign early_stop = r_early;

endmodule

// File: tb/tb_train_sequencer.sv
// Randomized bench for train_sequencer: a bench-side responder drives the
// handshakes and an epoch-level model predicts transactions and checkpoints.
module tb_train_sequencer;

    localparam int BITS = 16;
    localparam int ACCW = 16;
    localparam int PATW = 4;
    localparam longint ACC_MAX = (64'd1 << ACCW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [BITS-1:0]   n_train;
    logic [BITS-1:0]   n_valid;
    logic [BITS-1:0]   n_epoch;
    logic [PATW-1:0]   patience;
    logic [BITS-1:0]   sample_err;
    logic              fwd_req;
    logic              fwd_done;
    logic              bwd_req;
    logic              bwd_done;
    logic [BITS-1:0]   sample_idx;
    logic              tr;
    logic              vl;
    logic [BITS-1:0]   epoch_idx;
    logic              save;
    logic [ACCW-1:0]   best_err;
    logic              early_stop;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    train_sequencer #(
        .BITS     (BITS),
        .ACC_BITS (ACCW),
        .PAT_BITS (PATW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_train    (n_train),
        .n_valid    (n_valid),
        .n_epoch    (n_epoch),
        .patience   (patience),
        .sample_err (sample_err),
        .fwd_req    (fwd_req),
        .fwd_done   (fwd_done),
        .bwd_req    (bwd_req),
        .bwd_done   (bwd_done),
        .sample_idx (sample_idx),
        .tr         (tr),
        .vl         (vl),
        .epoch_idx  (epoch_idx),
        .save       (save),
        .best_err   (best_err),
        .early_stop (early_stop),
        .busy       (busy),
        .done       (done)
    );

    int total = 0;
    int bad   = 0;

    int errq[$];
    int expev[$];
    int obsev[$];
    int expsave[$];
    int obssave[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outvec();
        return {8'h0, fwd_req, bwd_req, tr, vl, save, early_stop, busy,
                done, sample_idx, epoch_idx, best_err};
    endfunction

    task automatic fill_rand(input int ne, input int nv, input bit big);
        errq.delete();
        for (int i = 0; i < ne * nv; i++) begin
            if (big) errq.push_back(int'($urandom_range(16'hFFFF, 16'hC000)));
            else     errq.push_back(int'($urandom_range(12, 0)));
        end
    endtask

    task automatic run_case(input string nm, input int nt, input int nv,
                            input int ne, input int pat, input int maxdly,
                            input bit noise, input bit do_rst);
        int best, stall, e, exp_early;
        int cyc, dly, vcnt, done_cyc, last_ev, end_ep, extra, nsv, nev;
        bit in_txn, fin, saw_tr, end_early;
        logic [ACCW-1:0] end_best;
        longint s;

        // Epoch-level model of the whole run
        expev.delete(); expsave.delete(); obsev.delete(); obssave.delete();
        best = 0; stall = 0; e = 0; exp_early = 0;
        while (e < ne) begin
            for (int i = 0; i < nt; i++) begin
                expev.push_back((1 << 16) | i);
                expev.push_back((3 << 16) | i);
            end
            s = 0;
            for (int i = 0; i < nv; i++) begin
                expev.push_back((2 << 16) | i);
                s += longint'(errq[e * nv + i]);
            end
            if (s > ACC_MAX) s = ACC_MAX;
            if (nv != 0 && (e == 0 || s < longint'(best))) begin
                best = int'(s);
                stall = 0;
                expsave.push_back(best);
            end else if (stall < 15) begin
                stall++;
            end
            e++;
            if (e == ne) break;
            if (pat != 0 && stall == pat) begin
                exp_early = 1;
                break;
            end
        end

        @(negedge clk);
        n_train  = 16'(nt);
        n_valid  = 16'(nv);
        n_epoch  = 16'(ne);
        patience = 4'(pat);
        start    = 1'b1;
        cyc = 0; dly = 0; vcnt = 0; done_cyc = 0; last_ev = 0; end_ep = 0;
        in_txn = 0; fin = 0; saw_tr = 0; end_early = 0; end_best = '0;

        while (!fin && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start      = 1'b0;
            fwd_done   = 1'b0;
            bwd_done   = 1'b0;
            sample_err = 16'($urandom);
            if (save) obssave.push_back(int'(best_err));
            if (tr) saw_tr = 1;
            if (done) begin
                done_cyc  = cyc;
                end_ep    = int'(epoch_idx);
                end_early = early_stop;
                end_best  = best_err;
                fin       = 1;
            end else if (do_rst && vl && epoch_idx == 16'd1) begin
                rst = 1'b1;
                @(negedge clk);
                check({nm, " rst outs"}, outvec(), 64'h0);
                rst = 1'b0;
                extra = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (done || busy || save) extra++;
                end
                check({nm, " rst quiet"}, 64'(extra), 64'h0);
                return;
            end else begin
                if (noise) begin
                    start    = busy && ($urandom_range(3, 0) == 0);
                    n_train  = 16'($urandom);
                    n_valid  = 16'($urandom);
                    n_epoch  = 16'($urandom);
                    patience = 4'($urandom);
                end
                if (!(fwd_req || bwd_req)) begin
                    in_txn = 0;
                end else begin
                    if (!in_txn) begin
                        in_txn = 1;
                        dly = int'($urandom_range(maxdly, 0));
                    end
                    if (dly == 0) begin
                        in_txn  = 0;
                        last_ev = cyc;
                        if (fwd_req) begin
                            fwd_done = 1'b1;
                            obsev.push_back(((tr ? 1 : 2) << 16) | int'(sample_idx));
                            if (vl) begin
                                sample_err = (vcnt < errq.size()) ? 16'(errq[vcnt]) : 16'h0;
                                vcnt++;
                            end
                        end else begin
                            bwd_done = 1'b1;
                            obsev.push_back((3 << 16) | int'(sample_idx));
                        end
                    end else begin
                        dly--;
                    end
                    if (noise && tr && fwd_req && $urandom_range(2, 0) == 0) bwd_done = 1'b1;
                    if (noise && bwd_req && $urandom_range(2, 0) == 0) fwd_done = 1'b1;
                end
            end
        end
        start    = 1'b0;
        fwd_done = 1'b0;
        bwd_done = 1'b0;

        if (!fin) begin
            check({nm, " timeout"}, 64'h1, 64'h0);
            return;
        end
        if (do_rst) check({nm, " rst reached"}, 64'h0, 64'h1);

        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) extra++;
        end
        check({nm, " extra done"}, 64'(extra), 64'h0);

        check({nm, " ev count"}, 64'(obsev.size()), 64'(expev.size()));
        nev = (obsev.size() < expev.size()) ? obsev.size() : expev.size();
        for (int i = 0; i < nev; i++) begin
            check($sformatf("%s ev%0d", nm, i), 64'(obsev[i]), 64'(expev[i]));
            if (obsev[i] != expev[i]) break;
        end
        check({nm, " save count"}, 64'(obssave.size()), 64'(expsave.size()));
        nsv = (obssave.size() < expsave.size()) ? obssave.size() : expsave.size();
        for (int i = 0; i < nsv; i++) begin
            check($sformatf("%s save%0d", nm, i), 64'(obssave[i]), 64'(expsave[i]));
        end
        check({nm, " epoch"}, 64'(end_ep), 64'(e));
        check({nm, " early"}, 64'(end_early), 64'(exp_early));
        check({nm, " best"}, 64'(end_best),
              64'(expsave.size() != 0 ? expsave[expsave.size() - 1] : 0));
        if (ne == 0) check({nm, " ne0 lat"}, 64'(done_cyc), 64'd2);
        else if (expev.size() != 0) check({nm, " done lag"}, 64'(done_cyc - last_ev), 64'd3);
        if (maxdly == 0) check({nm, " cycles"}, 64'(done_cyc), 64'(e * (2 * nt + nv + 1) + 2));
        if (nt == 0) check({nm, " no tr"}, 64'(saw_tr), 64'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; fwd_done = 1'b0; bwd_done = 1'b0;
        n_train = '0; n_valid = '0; n_epoch = '0; patience = '0;
        sample_err = '0;
        repeat (3) @(negedge clk);
        check("reset outs", outvec(), 64'h0);
        rst = 1'b0;

        errq = '{5, 5, 3, 3};
        run_case("basic", 2, 2, 2, 0, 0, 0, 0);

        errq = '{8, 8, 9, 9, 9, 9, 9, 9, 9, 9};
        run_case("early", 1, 1, 10, 2, 0, 0, 0);

        errq.delete();
        run_case("ne0", 2, 2, 0, 1, 0, 0, 0);
        fill_rand(2, 3, 0);
        run_case("nt0", 0, 3, 2, 0, 0, 0, 0);
        errq.delete();
        run_case("nv0", 2, 0, 3, 0, 0, 0, 0);
        run_case("nv0pat", 1, 0, 6, 2, 0, 0, 0);

        errq = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
        run_case("sat", 1, 3, 1, 0, 0, 0, 0);

        for (int k = 0; k < 10; k++) begin
            automatic int nt = int'($urandom_range(3, 0));
            automatic int nv = int'($urandom_range(3, 0));
            automatic int ne = int'($urandom_range(4, 0));
            automatic int pt = int'($urandom_range(3, 0));
            fill_rand(ne, nv, ($urandom_range(3, 0) == 0));
            run_case($sformatf("rand%0d", k), nt, nv, ne, pt, 7, 1, 0);
        end

        fill_rand(3, 2, 0);
        run_case("rstmid", 1, 2, 3, 0, 2, 0, 1);
        fill_rand(2, 2, 0);
        run_case("postrst", 2, 2, 2, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
